pulse_cmd_parser: RTL and testbench

- Upstream of the pulse generator: consumes bytes from the UART receiver and turns framed serial commands into the pulse-timing parameters (period, pulse 1 width, pulse 2 delay and width, config) the generator counts against.
- Double-buffered: frames write shadow registers; a COMMIT frame arms a copy into the active registers, applied only on the generator's sync pulse, so outputs never change mid-period.
- Answers every complete frame with ACK/NAK through the UART transmitter handshake.

---
 rtl/pulse_cmd_parser.sv | 254 +++++++++++++++++++++++++
 tb/tb_pulse_cmd_parser.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_parser.sv
// Framed serial command parser for the pulse generator: shadow/active timing
// registers, commit-on-sync transfer, ACK/NAK responses and inter-byte timeout.
module pulse_cmd_parser #(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int DEF_PERIOD     = 12000,
  parameter int DEF_P1_WIDTH   = 120,
  parameter int DEF_P2_DELAY   = 600,
  parameter int DEF_P2_WIDTH   = 240
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             sync_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] p1_width,
  output logic [CNT_W-1:0] p2_delay,
  output logic [CNT_W-1:0] p2_width,
  output logic [7:0]       cfg,
  output logic             commit_pending,
  output logic             params_updated,
  output logic             frame_err,
  output logic [2:0]       dbg_state
);

  // tx handshake: tx_valid rises with tx_data and both hold until a cycle
  // with tx_valid && tx_ready; the byte is consumed on that clock edge.
  // rx side has no backpressure: rx_valid is a one-cycle strobe per byte.

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SH_W = (CNT_W < 8) ? 8 : CNT_W;

  localparam logic [7:0] SOF        = 8'hA5;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] CMD_PERIOD = 8'h01;
  localparam logic [7:0] CMD_P1W    = 8'h02;
  localparam logic [7:0] CMD_P2D    = 8'h03;
  localparam logic [7:0] CMD_P2W    = 8'h04;
  localparam logic [7:0] CMD_CFG    = 8'h05;
  localparam logic [7:0] CMD_COMMIT = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        cmd_q;
  logic [SH_W-1:0]   data_q;
  logic [7:0]        xacc;
  logic [1:0]        dcnt;
  logic [TO_W-1:0]   tcnt;

  logic              byte_in;
  logic              frame_done;
  logic              timeout;
  logic              in_frame;
  logic              tcnt_hit;

  logic              chk_ok;
  logic              cmd_known;
  logic              frame_ack;
  logic [CNT_W-1:0]  payload;

  logic [CNT_W-1:0]  sh_period;
  logic [CNT_W-1:0]  sh_p1_width;
  logic [CNT_W-1:0]  sh_p2_delay;
  logic [CNT_W-1:0]  sh_p2_width;
  logic [7:0]        sh_cfg;

  logic              do_copy;
  logic              do_arm;

  assign dbg_state = state;
  assign in_frame  = (state == S_CMD) || (state == S_DATA) || (state == S_CHK);
  assign tcnt_hit  = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_in    = 1'b0;
    frame_done = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SOF) state_next = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          byte_in    = 1'b1;
          state_next = S_DATA;
        end else if (tcnt_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          byte_in = 1'b1;
          if (dcnt == 2'd3) state_next = S_CHK;
        end else if (tcnt_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          byte_in    = 1'b1;
          frame_done = 1'b1;
          state_next = S_RESP;
        end else if (tcnt_hit) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (tx_valid && tx_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- frame capture ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_q  <= 8'h00;
      data_q <= '0;
      xacc   <= 8'h00;
      dcnt   <= 2'd0;
    end else if (byte_in) begin
      if (state == S_CMD) begin
        cmd_q  <= rx_data;
        data_q <= '0;
        xacc   <= rx_data;
        dcnt   <= 2'd0;
      end else if (state == S_DATA) begin
        data_q <= SH_W'({data_q, rx_data});
        xacc   <= xacc ^ rx_data;
        dcnt   <= dcnt + 2'd1;
      end
    end
  end

  // Counts idle cycles since the last accepted byte; held at zero outside a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt <= '0;
    end else if (in_frame && !byte_in && !timeout) begin
      tcnt <= tcnt + TO_W'(1);
    end else begin
      tcnt <= '0;
    end
  end

  // ---------------- frame evaluation ----------------
  always_comb begin
    chk_ok    = (rx_data == xacc);
    payload   = CNT_W'(data_q);
    cmd_known = (cmd_q == CMD_PERIOD) || (cmd_q == CMD_P1W) || (cmd_q == CMD_P2D) ||
                (cmd_q == CMD_P2W) || (cmd_q == CMD_CFG) || (cmd_q == CMD_COMMIT);
    frame_ack = chk_ok && cmd_known &&
                !((cmd_q == CMD_PERIOD) && (payload < CNT_W'(2)));
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (frame_done) begin
        tx_valid  <= 1'b1;
        tx_data   <= frame_ack ? ACK : NAK;
        frame_err <= !frame_ack;
      end else if (timeout) begin
        frame_err <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // ---------------- shadow registers ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_period   <= CNT_W'(DEF_PERIOD);
      sh_p1_width <= CNT_W'(DEF_P1_WIDTH);
      sh_p2_delay <= CNT_W'(DEF_P2_DELAY);
      sh_p2_width <= CNT_W'(DEF_P2_WIDTH);
      sh_cfg      <= 8'h03;
    end else if (frame_done && frame_ack) begin
      case (cmd_q)
        CMD_PERIOD: sh_period   <= payload;
        CMD_P1W:    sh_p1_width <= payload;
        CMD_P2D:    sh_p2_delay <= payload;
        CMD_P2W:    sh_p2_width <= payload;
        CMD_CFG:    sh_cfg      <= data_q[7:0];
        default:    ;
      endcase
    end
  end

  // ---------------- commit / active registers ----------------
  // Only a sync_in seen while commit_pending is already high copies, so a sync
  // coincident with arming is ignored. A same-cycle shadow write misses the copy.
  assign do_copy = commit_pending && sync_in;
  assign do_arm  = frame_done && frame_ack && (cmd_q == CMD_COMMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period         <= CNT_W'(DEF_PERIOD);
      p1_width       <= CNT_W'(DEF_P1_WIDTH);
      p2_delay       <= CNT_W'(DEF_P2_DELAY);
      p2_width       <= CNT_W'(DEF_P2_WIDTH);
      cfg            <= 8'h03;
      commit_pending <= 1'b0;
      params_updated <= 1'b0;
    end else begin
      params_updated <= do_copy;
      if (do_copy) begin
        period   <= sh_period;
        p1_width <= sh_p1_width;
        p2_delay <= sh_p2_delay;
        p2_width <= sh_p2_width;
        cfg      <= sh_cfg;
      end
      if (do_arm) begin
        commit_pending <= 1'b1;
      end else if (do_copy) begin
        commit_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_cmd_parser.sv
// Randomized scoreboard bench for pulse_cmd_parser: frame drivers, a
// frame-level reference model, response/update monitors and a final report.
`timescale 1ns/1ps
module tb_pulse_cmd_parser;

  localparam int CNT_W = 24;
  localparam int TO    = 400;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;
  localparam logic [31:0] MASK = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic             sync_in = 1'b0;
  logic [CNT_W-1:0] period, p1_width, p2_delay, p2_width;
  logic [7:0]       cfg;
  logic             commit_pending, params_updated, frame_err;
  logic [2:0]       dbg_state;

  pulse_cmd_parser #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sync_in(sync_in),
    .period(period), .p1_width(p1_width), .p2_delay(p2_delay), .p2_width(p2_width),
    .cfg(cfg), .commit_pending(commit_pending), .params_updated(params_updated),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  int stab_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected or not seen (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] period, p1, p2d, p2w, cfg;
    int unsigned cyc;
  } pset_t;

  logic [39:0]  exp_q[$];   // {cycle tx_valid first seen, response byte}
  pset_t        exp_p[$];
  logic [31:0]  sh [5];
  logic [31:0]  act [5];
  bit           pend;
  int unsigned  arm_cyc;

  task automatic model_reset();
    sh  = '{32'd12000, 32'd120, 32'd600, 32'd240, 32'h03};
    act = sh;
    pend = 1'b0;
    arm_cyc = 0;
  endtask

  function automatic logic [7:0] good_chk(input logic [7:0] cmd, input logic [31:0] d);
    return cmd ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  function automatic bit model_ack(input logic [7:0] cmd, input logic [31:0] d, input logic [7:0] chk);
    bit known;
    known = (cmd >= 8'd1 && cmd <= 8'd5) || cmd == 8'd7;
    return (chk == good_chk(cmd, d)) && known && !(cmd == 8'd1 && (d & MASK) < 32'd2);
  endfunction

  task automatic model_copy(input int unsigned at);
    pset_t p;
    act = sh;
    pend = 1'b0;
    p.period = act[0]; p.p1 = act[1]; p.p2d = act[2]; p.p2w = act[3]; p.cfg = act[4];
    p.cyc = at;
    exp_p.push_back(p);
  endtask

  // ---------------- driver tasks ----------------
  bit   ready_mode = 1'b0;
  logic ready_force = 1'b1;

  initial forever begin
    @(posedge clk); #1;
    tx_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d,
                            input logic [7:0] chk, input bit sync_chk);
    int unsigned c;
    bit ack;
    send_byte(8'hA5, $urandom_range(0, 2));
    send_byte(cmd,        $urandom_range(0, 2));
    send_byte(d[31:24],   $urandom_range(0, 2));
    send_byte(d[23:16],   $urandom_range(0, 2));
    send_byte(d[15:8],    $urandom_range(0, 2));
    send_byte(d[7:0],     $urandom_range(0, 2));
    c = cyc;
    rx_data = chk;
    rx_valid = 1'b1;
    if (sync_chk) begin
      sync_in = 1'b1;
      if (pend && arm_cyc <= c) model_copy(c + 1);
    end
    ack = model_ack(cmd, d, chk);
    exp_q.push_back({32'(c + 1), ack ? ACK : NAK});
    if (!ack) exp_err++;
    else if (cmd == 8'd7) begin
      pend = 1'b1;
      arm_cyc = c + 1;
    end else if (cmd == 8'd5) sh[4] = {24'h0, d[7:0]};
    else sh[cmd - 8'd1] = d & MASK;
    tick();
    rx_valid = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic pulse_sync();
    int unsigned s;
    s = cyc;
    sync_in = 1'b1;
    if (pend && arm_cyc <= s) model_copy(s + 1);
    tick();
    sync_in = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_now("resp_timeout");
      exp_q.delete();
    end
    tick();
  endtask

  task automatic check_active(input string tag);
    check({tag, "_period"},   32'(period),   act[0]);
    check({tag, "_p1_width"}, 32'(p1_width), act[1]);
    check({tag, "_p2_delay"}, 32'(p2_delay), act[2]);
    check({tag, "_p2_width"}, 32'(p2_width), act[3]);
    check({tag, "_cfg"},      32'(cfg),      act[4]);
    check({tag, "_pending"},  32'(commit_pending), 32'(pend));
  endtask

  // ---------------- monitors / scoreboard ----------------
  bit tx_prev = 1'b0;
  bit prev_rst = 1'b0;
  logic [4*CNT_W+7:0] prev_out;

  always @(negedge clk) begin
    logic [39:0] head;
    pset_t p;
    if (!resetn) begin
      tx_prev = 1'b0;
    end else begin
      if (frame_err) err_seen++;
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          if (!tx_prev) fail_now("unexpected_resp");
        end else begin
          head = exp_q[0];
          if (!tx_prev) begin
            check("resp_latency", cyc, head[39:8]);
            check("resp_frame_err", 32'(frame_err), 32'(head[7:0] == NAK));
          end
          if (tx_ready) begin
            void'(exp_q.pop_front());
            check("resp_byte", 32'(tx_data), 32'(head[7:0]));
          end else begin
            check("resp_hold", 32'(tx_data), 32'(head[7:0]));
          end
        end
      end
      tx_prev = tx_valid && !tx_ready;
      if (params_updated) begin
        if (exp_p.size() == 0) fail_now("unexpected_update");
        else begin
          p = exp_p.pop_front();
          check("upd_cycle",    cyc, p.cyc);
          check("upd_period",   32'(period),   p.period);
          check("upd_p1_width", 32'(p1_width), p.p1);
          check("upd_p2_delay", 32'(p2_delay), p.p2d);
          check("upd_p2_width", 32'(p2_width), p.p2w);
          check("upd_cfg",      32'(cfg),      p.cfg);
          check("upd_pending_clr", 32'(commit_pending), 32'd0);
        end
      end
      if (prev_rst && !params_updated &&
          prev_out != {period, p1_width, p2_delay, p2_width, cfg}) stab_viol++;
    end
    prev_out = {period, p1_width, p2_delay, p2_width, cfg};
    prev_rst = resetn;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    logic [7:0]  cmd, chk;
    logic [31:0] d;
    int r;

    model_reset();
    repeat (5) tick();
    resetn = 1'b1;
    tick();
    check_active("reset");
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_updated", 32'(params_updated), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);

    // Write period, confirm active unchanged, then commit + sync.
    send_frame(8'h01, 32'h0000_2EE0, 8'hCF, 1'b0);
    wait_drain(50);
    check_active("pre_commit");
    send_frame(8'h07, 32'h0, 8'h07, 1'b0);
    wait_drain(50);
    check("armed_pending", 32'(commit_pending), 32'd1);
    repeat (3) tick();
    pulse_sync();
    tick();
    check_active("post_commit");

    // Bad checksum leaves shadow untouched.
    send_frame(8'h01, 32'h0000_1000, 8'h00, 1'b0);
    wait_drain(50);
    send_frame(8'h07, 32'h0, 8'h07, 1'b0);
    wait_drain(50);
    pulse_sync();
    tick();
    check_active("after_nak");

    // Inter-byte timeout.
    e0 = err_seen;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    repeat (TO - 5) tick();
    check("no_early_timeout", err_seen, e0);
    repeat (20) tick();
    check("timeout_frame_err", err_seen, e0 + 1);
    exp_err++;
    send_frame(8'h02, 32'h0000_0055, good_chk(8'h02, 32'h55), 1'b0);
    wait_drain(50);

    // Sync coincident with commit arming must not copy.
    send_frame(8'h07, 32'h0, 8'h07, 1'b1);
    wait_drain(50);
    check_active("coincident_sync");
    repeat (500) tick();
    pulse_sync();
    tick();
    check_active("late_sync");

    // Stalled transmitter with stray bytes during RESP.
    ready_force = 1'b0;
    send_frame(8'h03, 32'h0000_0321, good_chk(8'h03, 32'h321), 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 0) send_byte((i % 30 == 0) ? 8'hA5 : 8'($urandom_range(0, 255)), 0);
      else tick();
    end
    ready_force = 1'b1;
    wait_drain(50);
    send_frame(8'h01, 32'h0000_0001, good_chk(8'h01, 32'h1), 1'b0);
    wait_drain(50);

    // Randomized frames, random tx_ready, random syncs.
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 6) cmd = 8'($urandom_range(1, 5));
      else if (r == 6) cmd = 8'h07;
      else if (r == 7) cmd = 8'($urandom_range(8, 255));
      else if (r == 8) begin
        cmd = 8'h01;
        d = 32'($urandom_range(0, 1));
      end else cmd = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h06;
      chk = good_chk(cmd, d);
      if ($urandom_range(0, 6) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      send_frame(cmd, d, chk, 1'b0);
      wait_drain(300);
      if ($urandom_range(0, 2) == 0) pulse_sync();
    end
    send_frame(8'h07, 32'h0, 8'h07, 1'b0);
    wait_drain(300);
    pulse_sync();
    tick();
    check_active("random_end");
    ready_mode = 1'b0;
    ready_force = 1'b1;

    // Reset mid-frame restores defaults in shadow and active.
    send_frame(8'h04, 32'h0000_03E7, good_chk(8'h04, 32'h3E7), 1'b0);
    wait_drain(50);
    send_frame(8'h07, 32'h0, 8'h07, 1'b0);
    wait_drain(50);
    pulse_sync();
    send_frame(8'h01, 32'h0000_1388, good_chk(8'h01, 32'h1388), 1'b0);
    wait_drain(50);
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    resetn = 1'b0;
    repeat (3) tick();
    model_reset();
    resetn = 1'b1;
    tick();
    check_active("midreset");
    check("midreset_tx_valid", 32'(tx_valid), 32'd0);
    send_frame(8'h07, 32'h0, 8'h07, 1'b0);
    wait_drain(50);
    pulse_sync();
    tick();
    check_active("midreset_commit");

    repeat (5) tick();
    check("resp_queue_empty", exp_q.size(), 32'd0);
    check("update_queue_empty", exp_p.size(), 32'd0);
    check("frame_err_count", err_seen, exp_err);
    check("active_stable", stab_viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
